// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared LC-3b pipeline types: control word, register id, hazard scoreboard entry.
// Consumed by id_ex_hazard_reg and hazard_scoreboard (FORWARDING_EN selects stall policy).
package id_ex_hazard_reg_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] alu_op;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic       br_en;
    logic [1:0] pc_mux;
    logic [1:0] regfile_mux;
    logic       alu_mux;
  } lc3b_control_word;

  typedef struct packed {
    logic    vld;
    lc3b_reg dest;
    logic    is_load;
  } hazard_sb_entry_t;

  typedef enum logic [1:0] {
    SB_HOLD,
    SB_ISSUE,
    SB_BUBBLE,
    SB_FLUSH
  } sb_op_e;

  function automatic hazard_sb_entry_t make_entry(
    input lc3b_control_word c,
    input lc3b_reg          d
  );
    hazard_sb_entry_t e;
    e.vld     = c.load_regfile;
    e.dest    = d;
    e.is_load = c.mem_read & c.load_regfile;
    return e;
  endfunction

  function automatic logic src_hit(
    input hazard_sb_entry_t e,
    input lc3b_reg          src,
    input logic             src_vld
  );
    return src_vld & e.vld & (e.dest == src);
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_scoreboard.sv
// In-flight destination tracker (EX, MEM, WB) with RAW comparators.
// FORWARDING_EN: only a load sitting in EX can cause a hit.
module hazard_scoreboard
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  sb_op_e           op,
  input  hazard_sb_entry_t issue,
  input  lc3b_reg          src1,
  input  lc3b_reg          src2,
  input  logic             src1_vld,
  input  logic             src2_vld,
  output logic             raw_hit
);

  hazard_sb_entry_t sb [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else begin
      unique case (op)
        SB_HOLD: ;
        SB_ISSUE: begin
          sb[0] <= issue;
          for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
        end
        SB_BUBBLE: begin
          sb[0] <= '0;
          for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
        end
        SB_FLUSH: begin
          // EX is squashed and EX/MEM takes a bubble; only MEM moves on
          sb[0] <= '0;
          sb[1] <= '0;
          for (int i = 2; i < DEPTH; i++) sb[i] <= sb[i-1];
        end
        default: ;
      endcase
    end
  end

`ifdef FORWARDING_EN
  always_comb begin
    raw_hit = sb[0].is_load &
              (src_hit(sb[0], src1, src1_vld) |
               src_hit(sb[0], src2, src2_vld));
  end
`else
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      raw_hit = raw_hit |
                src_hit(sb[i], src1, src1_vld) |
                src_hit(sb[i], src2, src2_vld);
    end
  end
`endif

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register plus hazard controller (freeze, branch flush, RAW stall).
// FORWARDING_EN: load-use stall only; otherwise full scoreboard stall.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  lc3b_control_word id_ctrl,
  input  lc3b_control_word nop_ctrl,
  input  lc3b_reg          id_src1,
  input  lc3b_reg          id_src2,
  input  logic             id_src1_vld,
  input  logic             id_src2_vld,
  input  lc3b_reg          id_dest,
  input  logic             mem_br_taken,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             dmem_active,
  output lc3b_control_word ex_ctrl,
  output logic             load_pc,
  output logic             load_IF_ID,
  output logic             load_ID_EX,
  output logic             load_EX_MEM,
  output logic             load_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_EX_MEM,
  output logic             hazard_stall
);

  logic   raw_hit;
  logic   freeze;
  logic   branch;
  logic   stall;
  logic   advance;
  sb_op_e sb_op;

  // one-hot cycle class, highest priority first
  assign freeze  = ~imem_resp | (dmem_active & ~dmem_resp);
  assign branch  = ~freeze & mem_br_taken;
  assign stall   = ~freeze & ~mem_br_taken & raw_hit;
  assign advance = ~freeze & ~mem_br_taken & ~raw_hit;

  always_comb begin
    sb_op = SB_HOLD;
    unique case (1'b1)
      freeze:  sb_op = SB_HOLD;
      branch:  sb_op = SB_FLUSH;
      stall:   sb_op = SB_BUBBLE;
      advance: sb_op = SB_ISSUE;
      default: sb_op = SB_HOLD;
    endcase
  end

  hazard_scoreboard #(
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .op       (sb_op),
    .issue    (make_entry(id_ctrl, id_dest)),
    .src1     (id_src1),
    .src2     (id_src2),
    .src1_vld (id_src1_vld),
    .src2_vld (id_src2_vld),
    .raw_hit  (raw_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl <= nop_ctrl;
    end else begin
      unique case (1'b1)
        freeze:  ex_ctrl <= ex_ctrl;
        branch:  ex_ctrl <= nop_ctrl;
        stall:   ex_ctrl <= nop_ctrl;
        advance: ex_ctrl <= id_ctrl;
        default: ex_ctrl <= ex_ctrl;
      endcase
    end
  end

  assign load_pc      = branch | advance;
  assign load_IF_ID   = branch | advance;
  assign load_ID_EX   = ~freeze;
  assign load_EX_MEM  = ~freeze;
  assign load_MEM_WB  = ~freeze;
  assign flush_IF_ID  = branch;
  assign flush_EX_MEM = branch;
  assign hazard_stall = stall;

endmodule
